// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
// The master issues one request at a time and receives a one-cycle response pulse.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-writable word RAM plus a tohost/halt mailbox and cycle
// counter in an MMIO window, answering each request after WAIT_CYCLES wait states.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   dmem_if.slave       bus,
   output logic        halt,
   output logic [31:0] tohost
);
   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_LIMIT = 32'(4 * DEPTH_WORDS);
   localparam logic [31:0] CNT_ADDR  = MMIO_BASE + 32'd4;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    wait_cnt_reg, wait_cnt_next;
   logic          accept, ram_hit, tohost_hit, cnt_hit, req_err, ram_access;
   logic [AW-1:0] ram_idx;
   logic [31:0]   ram_word, tohost_merged, mmio_word;
   logic [31:0]   cycle_cnt_reg, rsp_word_reg, tohost_reg;
   logic          rsp_from_ram_reg, rsp_err_reg, halt_reg;

   // Ready is gated by the reset pin so it reads 0 while reset is held.
   assign bus.req_ready = reset && (state_reg == IDLE);
   assign accept        = bus.req_valid && bus.req_ready;

   assign ram_hit    = bus.req_addr < RAM_LIMIT;
   assign tohost_hit = bus.req_addr[31:2] == MMIO_BASE[31:2];
   assign cnt_hit    = bus.req_addr[31:2] == CNT_ADDR[31:2];
   assign req_err    = (bus.req_be == 4'd0) || !(ram_hit || tohost_hit || cnt_hit);
   assign ram_access = accept && ram_hit && !req_err;
   assign ram_idx    = bus.req_addr[AW+1:2];

   // The counter load reports the value the counter takes on the accept edge.
   assign mmio_word = tohost_hit ? tohost_reg : (cnt_hit ? cycle_cnt_reg + 32'd1 : 32'd0);

   // One byte-wide RAM per lane keeps byte writes and the registered read inferable.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
         if (ram_access) begin
            if (bus.req_we && bus.req_be[gi])
               lane_mem[ram_idx] <= bus.req_wdata[8*gi +: 8];
            lane_q <= lane_mem[ram_idx];
         end
      end

      assign ram_word[8*gi +: 8]      = lane_q;
      assign tohost_merged[8*gi +: 8] = bus.req_be[gi] ? bus.req_wdata[8*gi +: 8]
                                                       : tohost_reg[8*gi +: 8];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= IDLE;
         wait_cnt_reg     <= 4'd0;
         cycle_cnt_reg    <= 32'd0;
         rsp_word_reg     <= 32'd0;
         rsp_from_ram_reg <= 1'b0;
         rsp_err_reg      <= 1'b0;
         tohost_reg       <= 32'd0;
         halt_reg         <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
         if (accept) begin
            rsp_err_reg      <= req_err;
            rsp_from_ram_reg <= !bus.req_we && ram_hit && !req_err;
            rsp_word_reg     <= (!bus.req_we && !req_err && !ram_hit) ? mmio_word : 32'd0;
            if (bus.req_we && !req_err && tohost_hit) begin
               tohost_reg <= tohost_merged;
               halt_reg   <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      bus.rsp_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES > 0) begin
                  state_next    = WAIT;
                  wait_cnt_next = WAIT_LOAD;
               end else begin
                  state_next = RESP;
               end
            end
         end
         WAIT: begin
            if (wait_cnt_reg == 4'd0)
               state_next = RESP;
            else
               wait_cnt_next = wait_cnt_reg - 4'd1;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.rsp_rdata = rsp_from_ram_reg ? ram_word : rsp_word_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign halt          = halt_reg;
   assign tohost        = tohost_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with one wait state, one with three
// (used for the reset-during-wait case); a negedge monitor checks every response.
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        rst1_n, rst3_n;
   logic        halt1, halt3;
   logic [31:0] tohost1, tohost3;

   always #5 clk = ~clk;

   dmem_if bus1();
   dmem_if bus3();

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .MMIO_BASE(32'hFFFF_0000)) u_dut1 (
      .clk(clk), .reset(rst1_n), .bus(bus1), .halt(halt1), .tohost(tohost1)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .MMIO_BASE(32'hFFFF_0000)) u_dut3 (
      .clk(clk), .reset(rst3_n), .bus(bus3), .halt(halt3), .tohost(tohost3)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      string       name;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   exp_t e1, e3;
   int   checks = 0;
   int   errors = 0;
   int   tb_cyc = 0;
   int   unexp1 = 0;
   int   unexp3 = 0;

   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Monitor: pops the oldest expectation whenever a response pulse is seen.
   always @(negedge clk) begin
      if (bus1.rsp_valid === 1'b1) begin
         if (q1.size() == 0) unexp1++;
         else begin
            e1 = q1.pop_front();
            $display("dut1 %s: rdata=%h err=%b at cycle %0d", e1.name, bus1.rsp_rdata, bus1.rsp_err, tb_cyc);
            check32({e1.name, " rdata"}, bus1.rsp_rdata, e1.rdata);
            check32({e1.name, " err"}, 32'(bus1.rsp_err), 32'(e1.err));
            check32({e1.name, " latency"}, 32'(tb_cyc - e1.acc), 32'd1);
         end
      end
      if (bus3.rsp_valid === 1'b1) begin
         if (q3.size() == 0) unexp3++;
         else begin
            e3 = q3.pop_front();
            $display("dut3 %s: rdata=%h err=%b at cycle %0d", e3.name, bus3.rsp_rdata, bus3.rsp_err, tb_cyc);
            check32({e3.name, " rdata"}, bus3.rsp_rdata, e3.rdata);
            check32({e3.name, " err"}, 32'(bus3.rsp_err), 32'(e3.err));
            check32({e3.name, " latency"}, 32'(tb_cyc - e3.acc), 32'd3);
         end
      end
   end

   function automatic logic rdy(input int d);
      return (d == 1) ? bus1.req_ready : bus3.req_ready;
   endfunction

   task automatic drive(input int d, input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
      if (d == 1) begin
         bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = addr;
         bus1.req_wdata = wd; bus1.req_be = be;
      end else begin
         bus3.req_valid = v; bus3.req_we = we; bus3.req_addr = addr;
         bus3.req_wdata = wd; bus3.req_be = be;
      end
   endtask

   // Issue one request, record its expected response and accept edge.
   task automatic xact(input int d, input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] er, input logic ee);
      int   waited = 0;
      exp_t e;
      @(negedge clk);
      drive(d, 1'b1, we, addr, wd, be);
      while (!rdy(d) && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!rdy(d)) begin
         checks++;
         errors++;
         $display("FAIL %s accept timeout: req_ready 0, required 1", name);
      end else begin
         e.rdata = er; e.err = ee; e.acc = tb_cyc + 1; e.name = name;
         if (d == 1) q1.push_back(e);
         else q3.push_back(e);
      end
      @(negedge clk);
      drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((q1.size() != 0 || q3.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q1.size() != 0 || q3.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d responses outstanding, required 0", q1.size() + q3.size());
         q1.delete();
         q3.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst1_n = 1'b0;
      rst3_n = 1'b0;
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (3) @(negedge clk);

      // Reset values and the cycle counter ten edges after release
      check32("dut1 ready in reset", 32'(bus1.req_ready), 32'd0);
      rst1_n = 1'b1;
      #1;
      check32("dut1 ready after reset", 32'(bus1.req_ready), 32'd1);
      check32("dut1 halt after reset", 32'(halt1), 32'd0);
      check32("dut1 tohost after reset", tohost1, 32'd0);
      check32("dut1 rsp_valid after reset", 32'(bus1.rsp_valid), 32'd0);
      check32("dut1 rsp_rdata after reset", bus1.rsp_rdata, 32'd0);
      repeat (8) @(negedge clk);
      xact(1, "cycle counter load", 1'b0, 32'hFFFF_0004, 32'd0, 4'hF, 32'h0000_000A, 1'b0);

      // Store/load, byte enables, errors, boundaries
      xact(1, "store 0x40",        1'b1, 32'h40,   32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
      xact(1, "load 0x40",         1'b0, 32'h40,   32'd0,         4'hF, 32'hDEAD_BEEF, 1'b0);
      xact(1, "store byte0 0x40",  1'b1, 32'h40,   32'h0000_00AA, 4'h1, 32'd0, 1'b0);
      xact(1, "load merged 0x40",  1'b0, 32'h40,   32'd0,         4'hF, 32'hDEAD_BEAA, 1'b0);
      xact(1, "load unmapped",     1'b0, 32'h8000_0000, 32'd0,    4'hF, 32'd0, 1'b1);
      xact(1, "store be0",         1'b1, 32'h40,   32'h1234_5678, 4'h0, 32'd0, 1'b1);
      xact(1, "load after be0",    1'b0, 32'h40,   32'd0,         4'hF, 32'hDEAD_BEAA, 1'b0);
      xact(1, "store last word",   1'b1, 32'hFFC,  32'h55AA_55AA, 4'hF, 32'd0, 1'b0);
      xact(1, "load last word",    1'b0, 32'hFFE,  32'd0,         4'hF, 32'h55AA_55AA, 1'b0);
      xact(1, "load past ram",     1'b0, 32'h1000, 32'd0,         4'hF, 32'd0, 1'b1);
      xact(1, "load be0",          1'b0, 32'h44,   32'd0,         4'h0, 32'd0, 1'b1);
      xact(1, "store cycle cnt",   1'b1, 32'hFFFF_0004, 32'h99,   4'hF, 32'd0, 1'b0);
      drain();
      check32("dut1 halt before mailbox", 32'(halt1), 32'd0);
      check32("dut1 tohost before mailbox", tohost1, 32'd0);

      // Halt mailbox
      xact(1, "store tohost", 1'b1, 32'hFFFF_0000, 32'h0000_0001, 4'hF, 32'd0, 1'b0);
      check32("dut1 halt at accept", 32'(halt1), 32'd1);
      check32("dut1 tohost at accept", tohost1, 32'h0000_0001);
      xact(1, "store tohost byte1", 1'b1, 32'hFFFF_0000, 32'h0000_AB00, 4'h2, 32'd0, 1'b0);
      xact(1, "load tohost",        1'b0, 32'hFFFF_0002, 32'd0,         4'hF, 32'h0000_AB01, 1'b0);
      xact(1, "load 0x40 again",    1'b0, 32'h40,        32'd0,         4'hF, 32'hDEAD_BEAA, 1'b0);
      drain();
      check32("dut1 halt sticky", 32'(halt1), 32'd1);
      check32("dut1 tohost merged", tohost1, 32'h0000_AB01);
      check32("dut1 spurious responses", 32'(unexp1), 32'd0);

      // Reset during WAIT on the three-wait-state instance
      check32("dut3 ready in reset", 32'(bus3.req_ready), 32'd0);
      rst3_n = 1'b1;
      #1;
      check32("dut3 ready after reset", 32'(bus3.req_ready), 32'd1);
      xact(3, "dut3 store 0x40", 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
      drain();
      @(negedge clk);
      drive(3, 1'b1, 1'b0, 32'h40, 32'd0, 4'hF);
      check32("dut3 ready before dropped load", 32'(bus3.req_ready), 32'd1);
      @(negedge clk);
      drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      rst3_n = 1'b0;
      #1;
      check32("dut3 ready in mid reset", 32'(bus3.req_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst3_n = 1'b1;
      #1;
      check32("dut3 ready after mid reset", 32'(bus3.req_ready), 32'd1);
      repeat (8) @(negedge clk);
      check32("dut3 dropped response", 32'(unexp3), 32'd0);
      xact(3, "dut3 load 0x40 after reset", 1'b0, 32'h40, 32'd0, 4'hF, 32'hCAFE_F00D, 1'b0);
      drain();
      check32("dut3 spurious responses", 32'(unexp3), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
